adder_rr_scheduler: RTL and testbench

Shares one pipelined wide adder (fixed-latency, no stall input) among R requesters. Arbitration is round-robin, and every issued operation carries its requester ID through a tag pipeline that matches the adder latency. Results are buffered in a response FIFO so that backpressure on the response side never overflows the non-stallable adder. The block sits between the requester fabric and the wide adder instance.

---
 rtl/adder_rr_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_adder_rr_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// Round-robin front end sharing one fixed-latency pipelined wide adder among R requesters.
// Requester IDs ride a tag pipeline; results land in a credit-protected response FIFO.
module adder_rr_scheduler #(
    parameter int unsigned W     = 2048,
    parameter int unsigned R     = 4,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = (R > 1) ? $clog2(R) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*W-1:0]  req_a,
    input  logic [R*W-1:0]  req_b,
    input  logic [R-1:0]    req_cin,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    output logic            add_cin,
    output logic            add_in_valid,
    input  logic [W-1:0]    add_sum,
    input  logic            add_cout,
    input  logic            add_out_valid,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output logic [W-1:0]    rsp_sum,
    output logic            rsp_cout,
    output logic            busy,
    output logic            err
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IDX_W = ID_W + 1;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             found;
    logic             grant_ok;
    logic             hs;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic             sel_cin;
    logic [ID_W-1:0]  issue_id;

    logic [LAT-1:0]   tag_v;
    logic [ID_W-1:0]  tag_id [LAT];
    logic             head_v;
    logic [ID_W-1:0]  head_id;
    logic             push;
    logic             drop;
    logic             pop;

    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] out_next;

    logic [ID_W-1:0]  mem_id   [DEPTH];
    logic [W-1:0]     mem_sum  [DEPTH];
    logic             mem_cout [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign grant_ok = en && (outstanding < CNT_W'(DEPTH));
    assign hs       = found && grant_ok;

    // Round-robin search starting at ptr, wrapping modulo R
    always_comb begin
        found     = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        cand      = '0;
        for (int unsigned i = 0; i < R; i++) begin
            cand = IDX_W'(ptr) + IDX_W'(i);
            if (cand >= IDX_W'(R)) cand = cand - IDX_W'(R);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int unsigned i = 0; i < R; i++) begin
            if (ID_W'(i) == gnt_idx) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_cin = req_cin[i];
            end
        end
    end

    // Issue registers; operands hold their last value while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a        <= '0;
            add_b        <= '0;
            add_cin      <= 1'b0;
            add_in_valid <= 1'b0;
            issue_id     <= '0;
            ptr          <= '0;
        end else begin
            add_in_valid <= hs;
            if (hs) begin
                add_a    <= sel_a;
                add_b    <= sel_b;
                add_cin  <= sel_cin;
                issue_id <= gnt_idx;
                ptr      <= (gnt_idx == ID_W'(R - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
        end
    end

    // Tag pipeline aligned so its head meets add_out_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_v <= '0;
            for (int unsigned k = 0; k < LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_v[0]  <= add_in_valid;
            tag_id[0] <= issue_id;
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign head_v  = tag_v[LAT-1];
    assign head_id = tag_id[LAT-1];
    assign push    = head_v && add_out_valid;
    assign drop    = head_v && !add_out_valid;
    assign pop     = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else if (add_out_valid != head_v) err <= 1'b1;
    end

    // Credits: issued-not-returned plus buffered; a lost result releases its credit
    always_comb begin
        out_next = outstanding;
        if (hs)   out_next = out_next + CNT_W'(1);
        if (pop)  out_next = out_next - CNT_W'(1);
        if (drop) out_next = out_next - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            busy        <= 1'b0;
        end else begin
            outstanding <= out_next;
            busy        <= (out_next != '0);
        end
    end

    // Response FIFO; credits guarantee a push never finds it full without a pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem_id[k]   <= '0;
                mem_sum[k]  <= '0;
                mem_cout[k] <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_id[wr_ptr]   <= head_id;
                mem_sum[wr_ptr]  <= add_sum;
                mem_cout[wr_ptr] <= add_cout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_id    = mem_id[rd_ptr];
    assign rsp_sum   = mem_sum[rd_ptr];
    assign rsp_cout  = mem_cout[rd_ptr];

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: behavioural adder, round-robin/credit reference model and
// an in-order response scoreboard built from the arbitration and latency rules.
module tb_adder_rr_scheduler;
    localparam int unsigned W     = 128;
    localparam int unsigned R     = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CW    = W + 1;

    typedef struct {
        int         id;
        logic [W:0] res;
        int         rdy;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*W-1:0]  req_a;
    logic [R*W-1:0]  req_b;
    logic [R-1:0]    req_cin;
    logic [W-1:0]    add_a;
    logic [W-1:0]    add_b;
    logic            add_cin;
    logic            add_in_valid;
    logic [W-1:0]    add_sum;
    logic            add_cout;
    logic            add_out_valid;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            rsp_cout;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    adder_rr_scheduler #(.W(W), .R(R), .LAT(LAT), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_in_valid(add_in_valid),
        .add_sum(add_sum), .add_cout(add_cout), .add_out_valid(add_out_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .busy(busy), .err(err)
    );

    // Behavioural LAT-cycle adder (not reset, like the real instance)
    logic [LAT-1:0] pv = '0;
    logic [W-1:0]   ps [LAT];
    logic           pc [LAT];
    logic           inject;

    always @(posedge clk) begin
        pv[0] <= add_in_valid;
        {pc[0], ps[0]} <= CW'(add_a) + CW'(add_b) + CW'(add_cin);
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            ps[k] <= ps[k-1];
            pc[k] <= pc[k-1];
        end
    end

    assign add_out_valid = pv[LAT-1] | inject;
    assign add_sum       = ps[LAT-1];
    assign add_cout      = pc[LAT-1];

    int         checks = 0;
    int         errors = 0;
    ent_t       q[$];
    int         mptr, mout, now, prev_g;
    logic       merr;
    logic [W-1:0] op_a [R];
    logic [W-1:0] op_b [R];
    logic         op_cin [R];
    logic [W-1:0] prev_a, prev_b;
    logic         prev_cin;
    int           dut_hs;
    int           dut_gq[$];
    int           h0;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic pack();
        for (int i = 0; i < R; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
            req_cin[i]      = op_cin[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < R; i++) begin
            op_a[i]   = rnd();
            op_b[i]   = rnd();
            op_cin[i] = 1'($urandom_range(0, 1));
        end
        pack();
    endtask

    // One clock cycle: compare DUT against the model, then advance the model
    task automatic cycle();
        logic [R-1:0] er;
        int           g;
        int           obs_g;
        logic         ev;
        logic         pop;
        ent_t         e;
        #1;
        er = '0;
        g  = -1;
        if (en && mout < DEPTH)
            for (int k = 0; k < R; k++)
                if (g < 0 && req_valid[(mptr + k) % R]) g = (mptr + k) % R;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", CW'(req_ready), CW'(er));
        obs_g = -1;
        for (int k = 0; k < R; k++) if (req_ready[k] && req_valid[k]) obs_g = k;
        if (obs_g >= 0) begin
            dut_hs++;
            dut_gq.push_back(obs_g);
        end
        chk("add_in_valid", CW'(add_in_valid), CW'(prev_g >= 0));
        if (prev_g >= 0) begin
            chk("add_a", CW'(add_a), CW'(prev_a));
            chk("add_b", CW'(add_b), CW'(prev_b));
            chk("add_cin", CW'(add_cin), CW'(prev_cin));
        end
        ev = (q.size() > 0) && (q[0].rdy <= now);
        chk("rsp_valid", CW'(rsp_valid), CW'(ev));
        if (ev) begin
            chk("rsp_id", CW'(rsp_id), CW'(q[0].id));
            chk("rsp_sum", CW'(rsp_sum), CW'(q[0].res[W-1:0]));
            chk("rsp_cout", CW'(rsp_cout), CW'(q[0].res[W]));
        end
        chk("busy", CW'(busy), CW'(mout != 0));
        chk("err", CW'(err), CW'(merr));
        pop = ev && rsp_ready;
        if (pop) void'(q.pop_front());
        if (g >= 0) begin
            e.id  = g;
            e.res = CW'(op_a[g]) + CW'(op_b[g]) + CW'(op_cin[g]);
            e.rdy = now + 2 + LAT;
            q.push_back(e);
            mptr     = (g + 1) % R;
            prev_a   = op_a[g];
            prev_b   = op_b[g];
            prev_cin = op_cin[g];
        end
        prev_g = g;
        mout   = mout + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        if (inject) merr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        now++;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        rand_ops();
        repeat (LAT + 2) @(negedge clk);
        #1;
        chk("rst_req_ready", CW'(req_ready), '0);
        chk("rst_add_in_valid", CW'(add_in_valid), '0);
        chk("rst_add_a", CW'(add_a), '0);
        chk("rst_add_b", CW'(add_b), '0);
        chk("rst_add_cin", CW'(add_cin), '0);
        chk("rst_rsp_valid", CW'(rsp_valid), '0);
        chk("rst_rsp_id", CW'(rsp_id), '0);
        chk("rst_rsp_sum", CW'(rsp_sum), '0);
        chk("rst_rsp_cout", CW'(rsp_cout), '0);
        chk("rst_busy", CW'(busy), '0);
        chk("rst_err", CW'(err), '0);
        q.delete();
        mptr   = 0;
        mout   = 0;
        merr   = 1'b0;
        prev_g = -1;
        rst    = 1'b1;
    endtask

    initial begin
        now    = 0;
        dut_hs = 0;
        do_reset();

        // Single request from requester 2: all-ones + 1 wraps to zero with carry out
        en        = 1'b1;
        rsp_ready = 1'b1;
        op_a[2]   = '1;
        op_b[2]   = W'(1);
        op_cin[2] = 1'b0;
        pack();
        req_valid = 4'b0100;
        #1;
        chk("single_grant", CW'(req_ready), CW'(4'b0100));
        cycle();
        req_valid = '0;
        repeat (LAT + 1) cycle();
        #1;
        chk("single_rsp_valid", CW'(rsp_valid), CW'(1));
        chk("single_rsp_id", CW'(rsp_id), CW'(2));
        chk("single_rsp_sum", CW'(rsp_sum), CW'(0));
        chk("single_rsp_cout", CW'(rsp_cout), CW'(1));
        repeat (3) cycle();

        // Fairness from a fresh pointer
        do_reset();
        en        = 1'b1;
        rsp_ready = 1'b1;
        req_valid = '1;
        dut_gq.delete();
        for (int c = 0; c < 24 && dut_gq.size() < 8; c++) begin
            rand_ops();
            cycle();
        end
        req_valid = '0;
        for (int i = 0; i < 8; i++)
            chk("fair_order", CW'((i < dut_gq.size()) ? dut_gq[i] : 99), CW'(i % 4));
        repeat (8) cycle();

        // Backpressure: credits stop grants at DEPTH, one pop frees exactly one
        rsp_ready = 1'b0;
        req_valid = '1;
        h0 = dut_hs;
        repeat (10) begin
            rand_ops();
            cycle();
        end
        chk("bp_grants", CW'(dut_hs - h0), CW'(DEPTH));
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        h0 = dut_hs;
        repeat (4) cycle();
        chk("bp_regrant", CW'(dut_hs - h0), CW'(1));
        rsp_ready = 1'b1;
        repeat (30) begin
            rand_ops();
            cycle();
        end
        req_valid = '0;
        repeat (10) cycle();

        // en dropped after three grants: in-flight work still drains
        en        = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '1;
        h0 = dut_hs;
        repeat (3) begin
            rand_ops();
            cycle();
        end
        en = 1'b0;
        repeat (4) cycle();
        chk("en_grants", CW'(dut_hs - h0), CW'(3));
        rsp_ready = 1'b1;
        repeat (8) cycle();
        #1;
        chk("en_busy_low", CW'(busy), CW'(0));

        // Spurious adder result while idle
        req_valid = '0;
        inject    = 1'b1;
        cycle();
        inject = 1'b0;
        repeat (3) cycle();
        #1;
        chk("err_sticky", CW'(err), CW'(1));
        chk("err_no_rsp", CW'(rsp_valid), CW'(0));
        en        = 1'b1;
        req_valid = 4'b1010;
        repeat (4) begin
            rand_ops();
            cycle();
        end

        // Randomized traffic with random enable and response backpressure
        repeat (300) begin
            req_valid = R'($urandom);
            en        = ($urandom % 8) != 0;
            rsp_ready = ($urandom % 4) != 0;
            rand_ops();
            cycle();
        end
        en        = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (12) cycle();
        #1;
        chk("final_busy", CW'(busy), CW'(0));
        chk("final_sb_empty", CW'(q.size()), CW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
